// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
// The PRG and CHR regions are folded into one 19-bit memory image.
package cart_mem_pkg;
  localparam int PRG_AW = 18;
  localparam int CHR_AW = 17;
  localparam int MEM_AW = 19;
  localparam int DW     = 8;

  localparam logic       PRG_PREFIX = 1'b0;
  localparam logic [1:0] CHR_PREFIX = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  function automatic logic [MEM_AW-1:0] map_addr(
    input logic              own_chr,
    input logic [PRG_AW-1:0] prg_addr,
    input logic [CHR_AW-1:0] chr_addr
  );
    return own_chr ? {CHR_PREFIX, chr_addr} : {PRG_PREFIX, prg_addr};
  endfunction
endpackage

// File: rtl/cart_mem_priority.sv
// Grant selection: CHR normally wins, but PRG is forced through once
// CHR has been granted STARVE_LIMIT times in a row while PRG waited.
module cart_mem_priority #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic prg_req,
  input  logic chr_req,
  output logic grant_prg,
  output logic grant_chr
);
  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  logic [1:0] streak;

  always_comb begin
    grant_prg = prg_req && (!chr_req || streak == LIMIT);
    grant_chr = chr_req && !grant_prg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= 2'd0;
    end else if (en) begin
      if (grant_prg)
        streak <= 2'd0;
      else if (grant_chr)
        streak <= !prg_req ? 2'd0 : (streak == LIMIT) ? streak : streak + 2'd1;
    end
  end
endmodule

// File: rtl/cart_mem_arbiter.sv
// Two-client (PRG/CHR) arbiter in front of a single fixed-latency memory.
// One transaction at a time: IDLE -> ACCESS -> [WAIT] -> DONE -> IDLE.
module cart_mem_arbiter import cart_mem_pkg::*; #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              cart_clk_in,
  input  logic              reset_in,
  input  logic              prg_req_in,
  input  logic              prg_write_in,
  input  logic [PRG_AW-1:0] prg_address_in,
  input  logic [DW-1:0]     prg_data_in,
  output logic              prg_ack_out,
  output logic [DW-1:0]     prg_data_out,
  input  logic              chr_req_in,
  input  logic              chr_write_in,
  input  logic [CHR_AW-1:0] chr_address_in,
  input  logic [DW-1:0]     chr_data_in,
  output logic              chr_ack_out,
  output logic [DW-1:0]     chr_data_out,
  output logic [MEM_AW-1:0] mem_address_out,
  output logic [DW-1:0]     mem_data_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  input  logic [DW-1:0]     mem_data_in
);
  localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic       own_chr;
  logic       wr;
  logic [2:0] cnt;
  logic       grant_prg;
  logic       grant_chr;
  logic       sel_write;
  logic [DW-1:0] sel_data;

  cart_mem_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_pri (
    .clk      (cart_clk_in),
    .reset    (reset_in),
    .en       (state == IDLE),
    .prg_req  (prg_req_in),
    .chr_req  (chr_req_in),
    .grant_prg(grant_prg),
    .grant_chr(grant_chr)
  );

  assign sel_write = grant_chr ? chr_write_in : prg_write_in;
  assign sel_data  = grant_chr ? chr_data_in  : prg_data_in;

  // Outputs are registered: strobes are set on entry to ACCESS, acks on entry to DONE.
  always_ff @(posedge cart_clk_in) begin
    if (reset_in) begin
      state           <= IDLE;
      own_chr         <= 1'b0;
      wr              <= 1'b0;
      cnt             <= 3'd0;
      prg_ack_out     <= 1'b0;
      chr_ack_out     <= 1'b0;
      prg_data_out    <= '0;
      chr_data_out    <= '0;
      mem_address_out <= '0;
      mem_data_out    <= '0;
      mem_read_out    <= 1'b0;
      mem_write_out   <= 1'b0;
    end else begin
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      prg_ack_out   <= 1'b0;
      chr_ack_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_prg || grant_chr) begin
            own_chr         <= grant_chr;
            wr              <= sel_write;
            mem_address_out <= map_addr(grant_chr, prg_address_in, chr_address_in);
            if (sel_write) begin
              mem_write_out <= 1'b1;
              mem_data_out  <= sel_data;
            end else begin
              mem_read_out  <= 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (wr) begin
            prg_ack_out <= !own_chr;
            chr_ack_out <= own_chr;
            state       <= DONE;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Last WAIT cycle is exactly MEM_LATENCY after the strobe: data is valid now.
          if (cnt == 3'd0) begin
            if (own_chr) chr_data_out <= mem_data_in;
            else         prg_data_out <= mem_data_in;
            prg_ack_out <= !own_chr;
            chr_ack_out <= own_chr;
            state       <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Two arbiter instances (latency 2 / limit 3 and latency 1 / limit 2) checked
// every cycle against a transaction-schedule model, plus directed scenarios.
module tb_cart_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], preq[2], pwr[2], creq[2], cwr[2];
  logic [17:0] paddr[2];
  logic [16:0] caddr[2];
  logic [7:0]  pwd[2], cwd[2], mdin[2];
  logic        pack[2], cack[2], mrd[2], mwr[2];
  logic [7:0]  pdo[2], cdo[2], mdo[2];
  logic [18:0] maddr[2];

  cart_mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(3)) u0 (
    .cart_clk_in(clk), .reset_in(rst[0]),
    .prg_req_in(preq[0]), .prg_write_in(pwr[0]), .prg_address_in(paddr[0]), .prg_data_in(pwd[0]),
    .prg_ack_out(pack[0]), .prg_data_out(pdo[0]),
    .chr_req_in(creq[0]), .chr_write_in(cwr[0]), .chr_address_in(caddr[0]), .chr_data_in(cwd[0]),
    .chr_ack_out(cack[0]), .chr_data_out(cdo[0]),
    .mem_address_out(maddr[0]), .mem_data_out(mdo[0]), .mem_read_out(mrd[0]),
    .mem_write_out(mwr[0]), .mem_data_in(mdin[0]));

  cart_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(2)) u1 (
    .cart_clk_in(clk), .reset_in(rst[1]),
    .prg_req_in(preq[1]), .prg_write_in(pwr[1]), .prg_address_in(paddr[1]), .prg_data_in(pwd[1]),
    .prg_ack_out(pack[1]), .prg_data_out(pdo[1]),
    .chr_req_in(creq[1]), .chr_write_in(cwr[1]), .chr_address_in(caddr[1]), .chr_data_in(cwd[1]),
    .chr_ack_out(cack[1]), .chr_data_out(cdo[1]),
    .mem_address_out(maddr[1]), .mem_data_out(mdo[1]), .mem_read_out(mrd[1]),
    .mem_write_out(mwr[1]), .mem_data_in(mdin[1]));

  int checks = 0, failures = 0, cyc = 0;

  function automatic int lat(input int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int slim(input int i); return (i == 0) ? 3 : 2; endfunction
  function automatic int key(input int i, input logic [18:0] a); return i * (1 << 20) + int'(a); endfunction
  function automatic logic [7:0] fill(input int k); return 8'(k ^ (k >> 8) ^ (k >> 16)) ^ 8'h3C; endfunction

  logic [7:0] shadow[int];
  logic [7:0] rmem[int];
  function automatic logic [7:0] shv(input int k); return shadow.exists(k) ? shadow[k] : fill(k); endfunction
  function automatic logic [7:0] rmv(input int k); return rmem.exists(k) ? rmem[k] : fill(k); endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      if (failures <= 40) $display("FAIL %s inst%0d cyc=%0d actual=%h expected=%h", nm, i, cyc, a, e);
    end
  endtask

  // Model: each granted transaction is a schedule of ages; age 1 = strobe, age ack_at = ack.
  bit          mvalid[2], busy[2], own_chr[2], mw[2];
  int          age[2], ack_at[2], streak[2], rd_at[2], rd_key[2];
  logic [18:0] m_addr[2], e_addr[2];
  logic        e_rd[2], e_wr[2], e_pa[2], e_ca[2];
  logic [7:0]  e_md[2], e_pd[2], e_cd[2];
  bit          ack_p[2], ack_c[2];

  task automatic model_step(input int i);
    bit pick_prg;
    logic [7:0] v;
    if (rst[i] === 1'b1) begin
      mvalid[i] = 1; busy[i] = 0; streak[i] = 0;
      e_rd[i] = 0; e_wr[i] = 0; e_pa[i] = 0; e_ca[i] = 0;
      e_addr[i] = '0; e_md[i] = '0; e_pd[i] = '0; e_cd[i] = '0;
    end else if (mvalid[i]) begin
      e_rd[i] = 0; e_wr[i] = 0; e_pa[i] = 0; e_ca[i] = 0;
      if (busy[i]) begin
        if (age[i] == ack_at[i]) busy[i] = 0;
        else begin
          age[i]++;
          if (age[i] == ack_at[i]) begin
            if (own_chr[i]) e_ca[i] = 1; else e_pa[i] = 1;
            if (!mw[i]) begin
              v = shv(key(i, m_addr[i]));
              if (own_chr[i]) e_cd[i] = v; else e_pd[i] = v;
            end
          end
        end
      end else if (preq[i] || creq[i]) begin
        pick_prg = preq[i] && (!creq[i] || streak[i] == slim(i));
        if (pick_prg) streak[i] = 0;
        else streak[i] = preq[i] ? ((streak[i] < slim(i)) ? streak[i] + 1 : streak[i]) : 0;
        own_chr[i] = !pick_prg;
        mw[i]      = pick_prg ? pwr[i] : cwr[i];
        m_addr[i]  = pick_prg ? {1'b0, paddr[i]} : {2'b10, caddr[i]};
        busy[i] = 1; age[i] = 1;
        ack_at[i] = mw[i] ? 2 : 2 + lat(i);
        e_addr[i] = m_addr[i];
        if (mw[i]) begin
          e_wr[i] = 1;
          e_md[i] = pick_prg ? pwd[i] : cwd[i];
          shadow[key(i, m_addr[i])] = e_md[i];
        end else e_rd[i] = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        chk("mem_read", i, 32'(mrd[i]), 32'(e_rd[i]));
        chk("mem_write", i, 32'(mwr[i]), 32'(e_wr[i]));
        chk("mem_addr", i, 32'(maddr[i]), 32'(e_addr[i]));
        chk("mem_wdata", i, 32'(mdo[i]), 32'(e_md[i]));
        chk("prg_ack", i, 32'(pack[i]), 32'(e_pa[i]));
        chk("chr_ack", i, 32'(cack[i]), 32'(e_ca[i]));
        chk("prg_data", i, 32'(pdo[i]), 32'(e_pd[i]));
        chk("chr_data", i, 32'(cdo[i]), 32'(e_cd[i]));
      end
      ack_p[i] = (pack[i] === 1'b1);
      ack_c[i] = (cack[i] === 1'b1);
      model_step(i);
      mdin[i] = (cyc == rd_at[i]) ? rmv(rd_key[i]) : 8'($urandom);
      if (mwr[i] === 1'b1) rmem[key(i, maddr[i])] = mdo[i];
      if (mrd[i] === 1'b1) begin rd_at[i] = cyc + lat(i); rd_key[i] = key(i, maddr[i]); end
    end
  end

  logic        o_rd[32], o_wr[32], o_pa[32], o_ca[32];
  logic [18:0] o_addr[32];
  logic [7:0]  o_md[32], o_pd[32], o_cd[32];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic run_obs(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      o_rd[k] = mrd[i]; o_wr[k] = mwr[i]; o_pa[k] = pack[i]; o_ca[k] = cack[i];
      o_addr[k] = maddr[i]; o_md[k] = mdo[i]; o_pd[k] = pdo[i]; o_cd[k] = cdo[i];
    end
  endtask

  task automatic new_prg(input int i);
    pwr[i] = 1'($urandom); paddr[i] = {2'($urandom), 11'd0, 5'($urandom)}; pwd[i] = 8'($urandom);
  endtask
  task automatic new_chr(input int i);
    cwr[i] = 1'($urandom); caddr[i] = {2'($urandom), 10'd0, 5'($urandom)}; cwd[i] = 8'($urandom);
  endtask

  task automatic rand_drive(input int i);
    if (rst[i]) rst[i] = 0;
    else if ($urandom_range(0, 299) == 0) rst[i] = 1;
    if (preq[i]) begin
      if (ack_p[i]) begin if ($urandom_range(0, 3) != 0) preq[i] = 0; else new_prg(i); end
    end else if ($urandom_range(0, 2) == 0) begin preq[i] = 1; new_prg(i); end
    if (creq[i]) begin
      if (ack_c[i]) begin if ($urandom_range(0, 3) != 0) creq[i] = 0; else new_chr(i); end
    end else if ($urandom_range(0, 2) == 0) begin creq[i] = 1; new_chr(i); end
  endtask

  int na, seq[32], nacks, nc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; preq[i] = 0; pwr[i] = 0; paddr[i] = '0; pwd[i] = '0;
      creq[i] = 0; cwr[i] = 0; caddr[i] = '0; cwd[i] = '0;
      rd_at[i] = -1; mvalid[i] = 0; busy[i] = 0;
    end
    shadow[key(0, 19'h3C005)] = 8'hA5;
    rmem[key(0, 19'h3C005)]   = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_acks", i, 32'({pack[i], cack[i]}), 32'd0);
      chk("rst_strobes", i, 32'({mrd[i], mwr[i]}), 32'd0);
      chk("rst_addr", i, 32'(maddr[i]), 32'd0);
      chk("rst_data", i, 32'({pdo[i], cdo[i], mdo[i]}), 32'd0);
    end
    tick(); rst[0] = 0; rst[1] = 0;
    repeat (2) tick();

    // PRG read, latency 2
    preq[0] = 1; pwr[0] = 0; paddr[0] = 18'h3C005;
    run_obs(0, 5);
    chk("rd_strobe_t1", 0, 32'(o_rd[1]), 32'd1);
    chk("rd_addr_t1", 0, 32'(o_addr[1]), 32'h3C005);
    chk("rd_noack_t3", 0, 32'(o_pa[3]), 32'd0);
    chk("rd_ack_t4", 0, 32'(o_pa[4]), 32'd1);
    chk("rd_data_t4", 0, 32'(o_pd[4]), 32'hA5);
    tick(); preq[0] = 0;
    repeat (3) tick();

    // CHR write
    creq[0] = 1; cwr[0] = 1; caddr[0] = 17'h1FFFF; cwd[0] = 8'h5A;
    run_obs(0, 3);
    chk("wr_strobe_t1", 0, 32'({o_wr[1], o_rd[1]}), 32'd2);
    chk("wr_addr_t1", 0, 32'(o_addr[1]), 32'h5FFFF);
    chk("wr_data_t1", 0, 32'(o_md[1]), 32'h5A);
    chk("wr_ack_t2", 0, 32'(o_ca[2]), 32'd1);
    tick(); creq[0] = 0;
    repeat (3) tick();

    // Starvation: both held high, expect C C C P C C C P
    preq[0] = 1; pwr[0] = 1; paddr[0] = 18'h00010; pwd[0] = 8'h11;
    creq[0] = 1; cwr[0] = 1; caddr[0] = 17'h00020; cwd[0] = 8'h22;
    run_obs(0, 24);
    na = 0;
    for (int k = 0; k < 24; k++) begin
      if (o_pa[k] === 1'b1 && o_ca[k] === 1'b1) chk("ack_overlap", 0, 32'd1, 32'd0);
      if (o_pa[k] === 1'b1 || o_ca[k] === 1'b1) begin seq[na] = (o_ca[k] === 1'b1) ? 1 : 0; na++; end
    end
    chk("starve_nacks", 0, 32'(na), 32'd8);
    for (int j = 0; j < 8 && j < na; j++) chk("starve_order", 0, 32'(seq[j]), (j % 4 != 3) ? 32'd1 : 32'd0);
    tick(); preq[0] = 0; creq[0] = 0;
    repeat (3) tick();

    // Reset during WAIT of a CHR read with PRG pending
    creq[0] = 1; cwr[0] = 0; caddr[0] = 17'h00123;
    preq[0] = 1; pwr[0] = 0; paddr[0] = 18'h00456;
    run_obs(0, 2);
    chk("abort_chr_strobe", 0, 32'(o_rd[1]), 32'd1);
    chk("abort_chr_addr", 0, 32'(o_addr[1]), 32'h40123);
    tick(); rst[0] = 1;
    tick(); rst[0] = 0; creq[0] = 0;
    run_obs(0, 5);
    chk("abort_zero_ctl", 0, 32'({o_rd[0], o_wr[0], o_pa[0], o_ca[0]}), 32'd0);
    chk("abort_zero_addr", 0, 32'(o_addr[0]), 32'd0);
    chk("abort_zero_data", 0, 32'({o_md[0], o_pd[0], o_cd[0]}), 32'd0);
    chk("abort_prg_strobe", 0, 32'(o_rd[1]), 32'd1);
    chk("abort_prg_addr", 0, 32'(o_addr[1]), 32'h00456);
    chk("abort_prg_ack", 0, 32'(o_pa[4]), 32'd1);
    nc = 0;
    for (int k = 0; k < 5; k++) if (o_ca[k] === 1'b1) nc++;
    chk("abort_no_chr_ack", 0, 32'(nc), 32'd0);
    tick(); preq[0] = 0;
    repeat (3) tick();

    // Latency 1 back-to-back PRG reads: ack every 4 cycles
    preq[1] = 1; pwr[1] = 0; paddr[1] = 18'h00777;
    run_obs(1, 20);
    nacks = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_pa[k] === 1'b1) begin chk("lat1_ack_pos", 1, 32'(k % 4), 32'd3); nacks++; end
      if (o_ca[k] === 1'b1) chk("lat1_chr_ack", 1, 32'd1, 32'd0);
    end
    chk("lat1_nacks", 1, 32'(nacks), 32'd5);
    tick(); preq[1] = 0;
    repeat (3) tick();

    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) rand_drive(i);
    end
    for (int i = 0; i < 2; i++) begin preq[i] = 0; creq[i] = 0; rst[i] = 0; end
    repeat (12) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
